// File: rtl/instruction_queue.sv
// Circular instruction FIFO between fetch and decode. The head entry is presented
// fall-through; pops on Dec_flag, flushes on ROB_clear, holds everything while rdy_in is low.
module instruction_queue #(
  parameter int ADDR_W = 4
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        rdy_in,
  input  logic        IF_flag,
  input  logic [31:0] IF_inst,
  input  logic [31:0] IF_PC,
  input  logic [31:0] IF_BTB_PC,
  input  logic        IF_BTB_predict,
  output logic        IQ_full,
  output logic        IQ_flag,
  output logic [31:0] IQ_inst,
  output logic [31:0] IQ_PC,
  output logic [31:0] IQ_BTB_PC,
  output logic        IQ_BTB_predict,
  input  logic        Dec_flag,
  input  logic        ROB_clear
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_MAX  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH - 1);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] btb_pc;
    logic        btb_predict;
  } iq_entry_t;

  iq_entry_t         mem [DEPTH];
  iq_entry_t         head_ent;
  logic [ADDR_W-1:0] head, tail;
  logic [ADDR_W:0]   count;
  logic              flush, push, pop;

  // Flush outranks any same-cycle push/pop; rdy_in low freezes all state.
  assign flush = rdy_in && ROB_clear;
  assign push  = rdy_in && !ROB_clear && IF_flag && (count < CNT_MAX);
  assign pop   = rdy_in && !ROB_clear && Dec_flag && (count != '0);

  always_ff @(posedge clk_in) begin
    if (push) mem[tail] <= '{inst: IF_inst, pc: IF_PC, btb_pc: IF_BTB_PC,
                             btb_predict: IF_BTB_predict};
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Full is raised one slot early so a push already in flight still fits.
  assign head_ent       = mem[head];
  assign IQ_full        = (count >= CNT_FULL);
  assign IQ_flag        = rdy_in && (count != '0);
  assign IQ_inst        = head_ent.inst;
  assign IQ_PC          = head_ent.pc;
  assign IQ_BTB_PC      = head_ent.btb_pc;
  assign IQ_BTB_predict = head_ent.btb_predict;
endmodule

// File: tb/tb_instruction_queue.sv
// Bench for instruction_queue: a queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_instruction_queue;
  logic        clk_in = 0;
  logic        rst_n = 0;
  logic        rdy_in = 1;
  logic        IF_flag = 0;
  logic [31:0] IF_inst = 0, IF_PC = 0, IF_BTB_PC = 0;
  logic        IF_BTB_predict = 0;
  logic        IQ_full, IQ_flag;
  logic [31:0] IQ_inst, IQ_PC, IQ_BTB_PC;
  logic        IQ_BTB_predict;
  logic        Dec_flag = 0;
  logic        ROB_clear = 0;

  instruction_queue #(.ADDR_W(4)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .rdy_in(rdy_in),
    .IF_flag(IF_flag), .IF_inst(IF_inst), .IF_PC(IF_PC), .IF_BTB_PC(IF_BTB_PC),
    .IF_BTB_predict(IF_BTB_predict), .IQ_full(IQ_full), .IQ_flag(IQ_flag),
    .IQ_inst(IQ_inst), .IQ_PC(IQ_PC), .IQ_BTB_PC(IQ_BTB_PC),
    .IQ_BTB_predict(IQ_BTB_predict), .Dec_flag(Dec_flag), .ROB_clear(ROB_clear)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int passes = 0;
  int drops  = 0;
  bit chk_en = 0;
  logic [96:0] q[$];

  task automatic chk(input string name, input logic [96:0] act, input logic [96:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a plain queue of {inst, pc, btb_pc, predict} entries.
  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) q.delete();
    else if (rdy_in) begin
      if (ROB_clear) q.delete();
      else begin
        bit do_push, do_pop;
        do_push = IF_flag && q.size() < 16;
        do_pop  = Dec_flag && q.size() != 0;
        if (IF_flag && !do_push) drops++;
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back({IF_inst, IF_PC, IF_BTB_PC, IF_BTB_predict});
      end
    end
  end

  always @(negedge clk_in) begin
    if (chk_en) begin
      logic exp_flag;
      exp_flag = rst_n && rdy_in && q.size() != 0;
      chk("iq_flag", IQ_flag, exp_flag);
      chk("iq_full", IQ_full, q.size() >= 15);
      if (exp_flag)
        chk("head_entry", {IQ_inst, IQ_PC, IQ_BTB_PC, IQ_BTB_predict}, q[0]);
    end
  end

  task automatic tick();
    @(posedge clk_in); #1;
  endtask

  task automatic drive_push(input logic [31:0] pc);
    IF_flag = 1; IF_PC = pc; IF_inst = $urandom; IF_BTB_PC = pc + 4;
    IF_BTB_predict = 1'($urandom);
  endtask

  task automatic idle();
    IF_flag = 0; Dec_flag = 0; ROB_clear = 0; rdy_in = 1;
  endtask

  initial begin
    chk_en = 1;
    // 1: reset then idle, Dec_flag on empty queue
    tick(); tick();
    @(negedge clk_in);
    chk("rst_flag", IQ_flag, 0);
    chk("rst_full", IQ_full, 0);
    #1 rst_n = 1;
    tick();
    Dec_flag = 1; tick(); idle();
    @(negedge clk_in); chk("empty_pop_flag", IQ_flag, 0);
    tick();

    // 2: single pass-through
    IF_flag = 1; IF_inst = 32'h00500093; IF_PC = 0; IF_BTB_PC = 4; IF_BTB_predict = 0;
    tick(); idle();
    @(negedge clk_in);
    chk("pt_flag", IQ_flag, 1);
    chk("pt_entry", {IQ_inst, IQ_PC, IQ_BTB_PC, IQ_BTB_predict},
        {32'h00500093, 32'h0, 32'h4, 1'b0});
    Dec_flag = 1; tick(); idle();
    @(negedge clk_in); chk("pt_after_pop", IQ_flag, 0);
    tick();

    // 3: fill to 16, 17th dropped, drain in order
    for (int i = 0; i < 17; i++) begin
      drive_push(32'(i * 4)); tick();
      if (i == 14) begin
        @(negedge clk_in); chk("full_at_15", IQ_full, 1); #1;
      end
    end
    idle();
    chk("drop_count", 32'(drops), 1);
    drops = 0;
    for (int i = 0; i < 16; i++) begin
      Dec_flag = 1;
      @(negedge clk_in); chk("drain_pc", IQ_PC, 32'(i * 4));
      tick();
    end
    idle();
    @(negedge clk_in); chk("drained_flag", IQ_flag, 0);
    tick();

    // 4: streaming with concurrent push/pop across pointer wraps
    for (int c = 0; c <= 40; c++) begin
      if (c < 40) drive_push(32'h1000 + 32'(c * 4)); else IF_flag = 0;
      Dec_flag = (c >= 1);
      if (c >= 1) begin
        @(negedge clk_in);
        chk("stream_pc", IQ_PC, 32'h1000 + 32'((c - 1) * 4));
        chk("stream_full", IQ_full, 0);
      end
      tick();
    end
    idle();

    // 5: flush beats same-cycle push and pop
    for (int i = 0; i < 8; i++) begin drive_push(32'h80 + 32'(i * 4)); tick(); end
    drive_push(32'hdead0000); Dec_flag = 1; ROB_clear = 1;
    tick(); idle();
    @(negedge clk_in); chk("flush_flag", IQ_flag, 0);
    #1 drive_push(32'h100);
    tick(); idle();
    @(negedge clk_in);
    chk("post_flush_pc", IQ_PC, 32'h100);
    chk("post_flush_flag", IQ_flag, 1);
    #1 Dec_flag = 1; tick(); idle();

    // 6: rdy_in low freezes the queue
    for (int i = 0; i < 3; i++) begin drive_push(32'h200 + 32'(i * 4)); tick(); end
    idle();
    for (int i = 0; i < 4; i++) begin
      rdy_in = 0; IF_flag = 1'($urandom); Dec_flag = 1'($urandom); ROB_clear = 1'($urandom);
      @(negedge clk_in); chk("stall_flag", IQ_flag, 0);
      tick();
    end
    idle();
    @(negedge clk_in);
    chk("resume_pc", IQ_PC, 32'h200);
    chk("resume_flag", IQ_flag, 1);
    #1;
    for (int i = 0; i < 3; i++) begin Dec_flag = 1; tick(); end
    idle();
    @(negedge clk_in); chk("resume_drained", IQ_flag, 0);
    #1;

    // randomized traffic, including occasional asynchronous reset
    for (int n = 0; n < 2000; n++) begin
      rdy_in    = ($urandom_range(0, 9) != 0);
      Dec_flag  = 1'($urandom);
      ROB_clear = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 9) < 6) drive_push($urandom); else IF_flag = 0;
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 0;
        @(negedge clk_in);
        #1 rst_n = 1;
      end
      tick();
    end
    idle();
    tick();
    chk_en = 0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/instruction_queue.md
Name: instruction_queue

Overview:
- Circular FIFO between the instruction fetcher and the decoder.
- Buffers fetched instructions with their PC and branch-predictor (BTB) metadata.
- Presents the head entry to the decoder as a fall-through output; the entry pops when the decoder asserts Dec_flag.
- Flushes completely when the ROB signals a misprediction clear.

Parameters:
ADDR_W, 4, pointer width; queue depth DEPTH = 2**ADDR_W (16 entries)

Ports:
clk_in  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
rdy_in  input  1  global ready; when low the queue holds all state and IQ_flag is 0
IF_flag  input  1  fetcher pushes one entry this cycle
IF_inst  input  32  fetched instruction word
IF_PC  input  32  PC of fetched instruction
IF_BTB_PC  input  32  predicted next PC
IF_BTB_predict  input  1  predicted-taken bit
IQ_full  output  1  back-pressure to fetcher
IQ_flag  output  1  head entry valid for decoder
IQ_inst  output  32  head instruction
IQ_PC  output  32  head PC
IQ_BTB_PC  output  32  head predicted next PC
IQ_BTB_predict  output  1  head predicted-taken bit
Dec_flag  input  1  decoder consumed the head entry this cycle
ROB_clear  input  1  misprediction flush

Behaviour:
- Reset: asynchronous and active-low. While rst_n=0: head=0, tail=0, count=0, so IQ_flag=0 and IQ_full=0.
- Data outputs after reset: IQ_inst, IQ_PC, IQ_BTB_PC and IQ_BTB_predict are don't-care while IQ_flag=0. The storage array is not reset.
- State:
  - head and tail pointers, ADDR_W bits each, wrapping modulo DEPTH.
  - count, ADDR_W+1 bits, range 0..DEPTH.
- Head outputs:
  - IQ_inst, IQ_PC, IQ_BTB_PC and IQ_BTB_predict are driven combinationally from the entry at head.
  - IQ_flag = rdy_in && (count != 0).
  - Zero-latency read: an entry written at edge N is visible on the outputs after edge N.
- IQ_full = (count >= DEPTH-1). This is combinational from registered count.
  - The one-slot margin covers the fetcher's registered push: a push already in flight when IQ_full rises is still accepted.
- Push acceptance: push = rdy_in && IF_flag && (count < DEPTH).
  - On accept, the entry is written at tail and tail advances by 1.
  - A push attempted at count==DEPTH is silently dropped. This is a protocol violation; the bench flags it.
- Pop acceptance: pop = rdy_in && Dec_flag && (count != 0). On accept, head advances by 1.
  - Dec_flag with an empty queue is ignored.
- Count update per cycle:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged. Both pointers advance, and this is legal at any count including DEPTH-1.
- Wrap-around: pointers roll from DEPTH-1 to 0. Full and empty are distinguished by count, not by pointer equality.
- Flush: ROB_clear && rdy_in has highest priority. At the next edge head=tail=count=0.
  - Any same-cycle push or pop is discarded.
  - IQ_flag=0 in the cycle after the flush.
- rdy_in=0: no pointer or count change regardless of IF_flag, Dec_flag or ROB_clear.
- Reset mid-operation: all contents are discarded immediately, with no clock edge required.
- Storage is inferred as a register array of DEPTH x 97 bits (32+32+32+1). No read-during-write hazard: the head read is combinational from the array, and a simultaneous push at count==0 is not visible until the next cycle.

Test Plan:
1. Reset then idle: rst_n low for 2 cycles -> IQ_flag=0, IQ_full=0. Dec_flag=1 with the queue empty -> count stays 0.
2. Single pass-through: push inst=0x00500093, PC=0x0, BTB_PC=0x4, predict=0 -> next cycle IQ_flag=1 with identical fields. Dec_flag=1 -> following cycle IQ_flag=0.
3. Fill and full: push 15 entries with Dec_flag=0 -> IQ_full=1 at count=15. A 16th in-flight push is accepted (count=16). A 17th push is dropped. Pop 16 -> PCs 0x0..0x3C come out in order.
4. Wrap-around with concurrent push/pop: stream 40 entries while popping every cycle after the first push -> count holds at 1, and PCs emerge in order across 2.5 pointer wraps.
5. Flush: with 8 entries queued, assert ROB_clear together with IF_flag and Dec_flag -> next cycle count=0 and IQ_flag=0. A subsequent push of PC=0x100 appears at the head.
6. rdy_in low: with 3 entries queued, drop rdy_in for 4 cycles while toggling IF_flag, Dec_flag and ROB_clear -> IQ_flag=0 and count stays 3. After rdy_in rises, the original head is presented.
